// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO instruction sequencer: op encodings,
// FSM state type and the divide-by-zero LO value.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [2:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Issues HI/LO writes for MULT/MULTU/MTHI/MTLO and sequences the external
// DIV/DIVU units through start/busy, stalling the PC while a divide runs.
module muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [63:0] mult_res,
  input  logic [63:0] multu_res,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  input  logic        div_busy,
  input  logic        divu_busy,
  output logic        div_start,
  output logic        divu_start,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  output logic        stall,
  output logic        hi_w,
  output logic        lo_w,
  output logic [31:0] hi_in,
  output logic [31:0] lo_in,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       dividend_reg, divisor_reg;
  logic              sel_u_reg;
  logic              div_start_reg, divu_start_reg;
  logic              done_reg, err_reg;

  logic              accept;
  logic              div0_wr;
  logic              timeout;
  logic              sel_busy;
  logic              hi_w_c, lo_w_c, stall_c;
  logic [31:0]       hi_in_c, lo_in_c;

  assign sel_busy = sel_u_reg ? divu_busy : div_busy;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_w_c     = 1'b0;
    lo_w_c     = 1'b0;
    hi_in_c    = '0;
    lo_in_c    = '0;
    stall_c    = 1'b0;
    accept     = 1'b0;
    div0_wr    = 1'b0;
    timeout    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT: begin
              hi_w_c  = 1'b1;
              lo_w_c  = 1'b1;
              hi_in_c = mult_res[63:32];
              lo_in_c = mult_res[31:0];
            end
            OP_MULTU: begin
              hi_w_c  = 1'b1;
              lo_w_c  = 1'b1;
              hi_in_c = multu_res[63:32];
              lo_in_c = multu_res[31:0];
            end
            OP_MTHI: begin
              hi_w_c  = 1'b1;
              hi_in_c = rs_val;
            end
            OP_MTLO: begin
              lo_w_c  = 1'b1;
              lo_in_c = rs_val;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero never reaches the divider: result is fixed.
              if (rt_val == 32'd0) begin
                hi_w_c  = 1'b1;
                lo_w_c  = 1'b1;
                hi_in_c = rs_val;
                lo_in_c = DIV0_LO;
                div0_wr = 1'b1;
              end else begin
                stall_c    = 1'b1;
                accept     = 1'b1;
                state_next = ST_START;
              end
            end
            default: ;
          endcase
        end
      end

      ST_START: begin
        stall_c    = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (!sel_busy) begin
          stall_c    = 1'b1;
          state_next = ST_WRITE;
        end else if (cnt_reg == CNT_MAX) begin
          // Abandon: drop stall now so the PC moves past this DIV.
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          stall_c  = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_WRITE: begin
        hi_w_c     = 1'b1;
        lo_w_c     = 1'b1;
        hi_in_c    = sel_u_reg ? divu_r : div_r;
        lo_in_c    = sel_u_reg ? divu_q : div_q;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      dividend_reg   <= '0;
      divisor_reg    <= '0;
      sel_u_reg      <= 1'b0;
      div_start_reg  <= 1'b0;
      divu_start_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        dividend_reg <= rs_val;
        divisor_reg  <= rt_val;
        sel_u_reg    <= (op == OP_DIVU);
      end
      div_start_reg  <= accept && (op == OP_DIV);
      divu_start_reg <= accept && (op == OP_DIVU);
      // Aligned with the WRITE cycle; a divide-by-zero pulses on the next cycle.
      done_reg <= (state_next == ST_WRITE) || div0_wr;
      err_reg  <= err_reg || timeout;
    end
  end

  // Reset suppresses every combinational side effect on HI/LO and the PC.
  assign stall      = stall_c && rst;
  assign hi_w       = hi_w_c && rst;
  assign lo_w       = lo_w_c && rst;
  assign hi_in      = hi_in_c;
  assign lo_in      = lo_in_c;
  assign div_start  = div_start_reg;
  assign divu_start = divu_start_reg;
  assign dividend   = dividend_reg;
  assign divisor    = divisor_reg;
  assign done       = done_reg;
  assign err        = err_reg;

  logic unused_ok;
  assign unused_ok = is_div_op(op);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: default instance plus a WAIT_LIMIT=8
// instance sharing the same stimulus for the timeout scenario.
module tb_muldiv_sequencer;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic [63:0] mult_res = '0, multu_res = '0;
  logic [31:0] div_q = '0, div_r = '0, divu_q = '0, divu_r = '0;
  logic        div_busy = 1'b0, divu_busy = 1'b0;

  logic        div_start, divu_start, stall, hi_w, lo_w, done, err;
  logic [31:0] dividend, divisor, hi_in, lo_in;
  logic        t_div_start, t_divu_start, t_stall, t_hi_w, t_lo_w, t_done, t_err;
  logic [31:0] t_dividend, t_divisor, t_hi_in, t_lo_in;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mult_res(mult_res), .multu_res(multu_res),
    .div_q(div_q), .div_r(div_r), .divu_q(divu_q), .divu_r(divu_r),
    .div_busy(div_busy), .divu_busy(divu_busy),
    .div_start(div_start), .divu_start(divu_start),
    .dividend(dividend), .divisor(divisor), .stall(stall),
    .hi_w(hi_w), .lo_w(lo_w), .hi_in(hi_in), .lo_in(lo_in),
    .done(done), .err(err)
  );

  muldiv_sequencer #(.WAIT_LIMIT(8)) dut8 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mult_res(mult_res), .multu_res(multu_res),
    .div_q(div_q), .div_r(div_r), .divu_q(divu_q), .divu_r(divu_r),
    .div_busy(div_busy), .divu_busy(divu_busy),
    .div_start(t_div_start), .divu_start(t_divu_start),
    .dividend(t_dividend), .divisor(t_divisor), .stall(t_stall),
    .hi_w(t_hi_w), .lo_w(t_lo_w), .hi_in(t_hi_in), .lo_in(t_lo_in),
    .done(t_done), .err(t_err)
  );

  // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one divide as the core would (instruction held while stalled) and
  // models the selected divider: busy from the start cycle for blen cycles.
  // The unselected busy is held high throughout.
  task automatic run_div(input logic [2:0] dop, input logic [31:0] a, input logic [31:0] b,
                         input int blen, input int chg_at, input logic [31:0] a2,
                         output int stalls, output int starts, output int wrong_starts,
                         output int wcyc, output logic [31:0] whi, output logic [31:0] wlo,
                         output logic wdone, output logic held);
    int bcnt;
    logic got;
    stalls = 0; starts = 0; wrong_starts = 0; wcyc = -1;
    whi = '0; wlo = '0; wdone = 1'b0; held = 1'b1; bcnt = 0; got = 1'b0;
    op_valid = 1'b1; op = dop; rs_val = a; rt_val = b;
    div_busy = (dop == OP_DIVU);
    divu_busy = (dop == OP_DIV);
    #1;
    if (stall) stalls++;
    for (int cyc = 1; cyc < 200 && !got; cyc++) begin
      step();
      if (div_start || divu_start) begin
        starts++;
        bcnt = blen;
        if ((dop == OP_DIV) ? divu_start : div_start) wrong_starts++;
      end
      if (dop == OP_DIV) div_busy = (bcnt > 0);
      else divu_busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
      if (cyc == chg_at) rs_val = a2;
      if (dividend !== a || divisor !== b) held = 1'b0;
      #1;
      if (stall) stalls++;
      if (hi_w && lo_w) begin
        got = 1'b1; wcyc = cyc; whi = hi_in; wlo = lo_in; wdone = done;
      end
    end
    op_valid = 1'b0; div_busy = 1'b0; divu_busy = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b1; op = OP_DIV; rs_val = 32'd9; rt_val = 32'd3;
    step(); step(); #1;
    total++;
    if ({stall, hi_w, lo_w} !== 3'b000) begin
      bad++; $display("FAIL reset_comb: got stall/hi_w/lo_w=%b want 000", {stall, hi_w, lo_w});
    end
    total++;
    if ({div_start, divu_start, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_regs: got start/ustart/done/err=%b want 0000", {div_start, divu_start, done, err});
    end
    total++;
    if (dividend !== 32'd0 || divisor !== 32'd0) begin
      bad++; $display("FAIL reset_operands: got %h/%h want 0/0", dividend, divisor);
    end
    total++;
    if (t_err !== 1'b0) begin
      bad++; $display("FAIL reset_err8: got %b want 0", t_err);
    end
    $display("reset: stall=%b hi_w=%b dividend=%h", stall, hi_w, dividend);
    op_valid = 1'b0; rst = 1'b1;
    step();
  endtask

  task automatic test_mult();
    op_valid = 1'b1; op = OP_MULT; rs_val = 32'hFFFF_FFFD; rt_val = 32'd5;
    mult_res = 64'hFFFF_FFFF_FFFF_FFF1; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b110 || hi_in !== 32'hFFFF_FFFF || lo_in !== 32'hFFFF_FFF1) begin
      bad++; $display("FAIL mult: got w=%b hi=%h lo=%h want 110 ffffffff fffffff1", {hi_w, lo_w, stall}, hi_in, lo_in);
    end
    $display("mult: hi=%h lo=%h stall=%b", hi_in, lo_in, stall);
    step();
    op = OP_MULTU; multu_res = 64'h0000_0004_FFFF_FFF1; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b110 || hi_in !== 32'h0000_0004 || lo_in !== 32'hFFFF_FFF1) begin
      bad++; $display("FAIL multu: got w=%b hi=%h lo=%h want 110 00000004 fffffff1", {hi_w, lo_w, stall}, hi_in, lo_in);
    end
    $display("multu: hi=%h lo=%h", hi_in, lo_in);
    step();
    op = OP_MTHI; rs_val = 32'h1234_5678; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b100 || hi_in !== 32'h1234_5678) begin
      bad++; $display("FAIL mthi: got w=%b hi=%h want 100 12345678", {hi_w, lo_w, stall}, hi_in);
    end
    $display("mthi: hi=%h", hi_in);
    step();
    op = OP_MTLO; rs_val = 32'h8765_4321; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b010 || lo_in !== 32'h8765_4321) begin
      bad++; $display("FAIL mtlo: got w=%b lo=%h want 010 87654321", {hi_w, lo_w, stall}, lo_in);
    end
    $display("mtlo: lo=%h", lo_in);
    step();
    op = 3'd6; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b000) begin
      bad++; $display("FAIL op6: got w=%b want 000", {hi_w, lo_w, stall});
    end
    step();
    op = OP_MULT; op_valid = 1'b0; #1;
    total++;
    if ({hi_w, lo_w, stall, done} !== 4'b0000) begin
      bad++; $display("FAIL not_valid: got w=%b want 0000", {hi_w, lo_w, stall, done});
    end
    $display("idle ops: w=%b done=%b", {hi_w, lo_w, stall}, done);
    step();
  endtask

  task automatic test_div_by_zero();
    op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd0; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b110 || hi_in !== 32'd100 || lo_in !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL divu0: got w=%b hi=%h lo=%h want 110 00000064 ffffffff", {hi_w, lo_w, stall}, hi_in, lo_in);
    end
    $display("divu0: hi=%h lo=%h stall=%b", hi_in, lo_in, stall);
    step();
    op_valid = 1'b0; #1;
    total++;
    if ({done, div_start, divu_start, stall} !== 4'b1000) begin
      bad++; $display("FAIL divu0_done: got done/start/ustart/stall=%b want 1000", {done, div_start, divu_start, stall});
    end
    step(); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL divu0_done_end: got %b want 0", done);
    end
    step();
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'hFFFF_FFFB; rt_val = 32'd0; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b110 || hi_in !== 32'hFFFF_FFFB || lo_in !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL div0: got w=%b hi=%h lo=%h want 110 fffffffb ffffffff", {hi_w, lo_w, stall}, hi_in, lo_in);
    end
    $display("div0: hi=%h lo=%h", hi_in, lo_in);
    op_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_div();
    int stalls, starts, wrong, wcyc;
    logic [31:0] whi, wlo;
    logic wdone, held;
    div_q = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFF;
    divu_q = 32'h1111_1111; divu_r = 32'h2222_2222;
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32, -1, 32'd0, stalls, starts, wrong, wcyc, whi, wlo, wdone, held);
    $display("div: stalls=%0d starts=%0d wcyc=%0d hi=%h lo=%h done=%b", stalls, starts, wcyc, whi, wlo, wdone);
    total++;
    if (stalls !== 34) begin
      bad++; $display("FAIL div_stall_len: got %0d want 34", stalls);
    end
    total++;
    if (starts !== 1 || wrong !== 0) begin
      bad++; $display("FAIL div_start: got starts=%0d wrong=%0d want 1/0", starts, wrong);
    end
    total++;
    if (wcyc !== 34) begin
      bad++; $display("FAIL div_write_cycle: got %0d want 34", wcyc);
    end
    total++;
    if (whi !== 32'hFFFF_FFFF || wlo !== 32'hFFFF_FFFD || wdone !== 1'b1) begin
      bad++; $display("FAIL div_result: got hi=%h lo=%h done=%b want ffffffff fffffffd 1", whi, wlo, wdone);
    end
    total++;
    if (held !== 1'b1) begin
      bad++; $display("FAIL div_operands: got held=%b want 1", held);
    end
    #1;
    total++;
    if ({done, stall, err} !== 3'b000) begin
      bad++; $display("FAIL div_after: got done/stall/err=%b want 000", {done, stall, err});
    end
    step();
  endtask

  task automatic test_div_fast();
    int stalls, starts, wrong, wcyc;
    logic [31:0] whi, wlo;
    logic wdone, held;
    div_q = 32'd3; div_r = 32'd2;
    run_div(OP_DIV, 32'd20, 32'd6, 1, -1, 32'd0, stalls, starts, wrong, wcyc, whi, wlo, wdone, held);
    $display("div_fast: stalls=%0d wcyc=%0d hi=%h lo=%h", stalls, wcyc, whi, wlo);
    total++;
    if (stalls !== 3 || wcyc !== 3) begin
      bad++; $display("FAIL div_fast_timing: got stalls=%0d wcyc=%0d want 3/3", stalls, wcyc);
    end
    total++;
    if (whi !== 32'd2 || wlo !== 32'd3 || wdone !== 1'b1) begin
      bad++; $display("FAIL div_fast_result: got hi=%h lo=%h done=%b want 2 3 1", whi, wlo, wdone);
    end
  endtask

  task automatic test_divu_latched();
    int stalls, starts, wrong, wcyc;
    logic [31:0] whi, wlo;
    logic wdone, held;
    divu_q = 32'd14; divu_r = 32'd2; div_q = 32'h0000_AAAA; div_r = 32'h0000_BBBB;
    run_div(OP_DIVU, 32'd100, 32'd7, 5, 4, 32'd500, stalls, starts, wrong, wcyc, whi, wlo, wdone, held);
    $display("divu: stalls=%0d wcyc=%0d hi=%h lo=%h held=%b", stalls, wcyc, whi, wlo, held);
    total++;
    if (held !== 1'b1) begin
      bad++; $display("FAIL divu_operands_held: got %b want 1", held);
    end
    total++;
    if (whi !== 32'd2 || wlo !== 32'd14 || stalls !== 7 || starts !== 1 || wrong !== 0) begin
      bad++; $display("FAIL divu_result: got hi=%h lo=%h stalls=%0d starts=%0d/%0d want 2 e 7 1/0", whi, wlo, stalls, starts, wrong);
    end
    #1;
    total++;
    if (dividend !== 32'd100 || divisor !== 32'd7) begin
      bad++; $display("FAIL divu_operands_after: got %h/%h want 64/7", dividend, divisor);
    end
    step();
  endtask

  task automatic test_reset_mid_divide();
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd77; rt_val = 32'd5;
    step();
    div_busy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0; #1;
    total++;
    if ({stall, hi_w, lo_w} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_comb: got stall/hi_w/lo_w=%b want 000", {stall, hi_w, lo_w});
    end
    step();
    rst = 1'b1; op_valid = 1'b0; #1;
    total++;
    if ({stall, hi_w, lo_w, div_start, done} !== 5'b00000 || dividend !== 32'd0) begin
      bad++; $display("FAIL rst_mid_idle: got flags=%b dividend=%h want 00000 0", {stall, hi_w, lo_w, div_start, done}, dividend);
    end
    $display("reset mid-divide: stall=%b dividend=%h", stall, dividend);
    step();
    div_busy = 1'b0; op_valid = 1'b1; op = OP_MTLO; rs_val = 32'hCAFE_F00D; #1;
    total++;
    if ({hi_w, lo_w, stall} !== 3'b010 || lo_in !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL rst_mid_mtlo: got w=%b lo=%h want 010 cafef00d", {hi_w, lo_w, stall}, lo_in);
    end
    $display("mtlo after reset: lo=%h", lo_in);
    op_valid = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int stalls, writes, early_err;
    logic last_stall;
    stalls = 0; writes = 0; early_err = 0; last_stall = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd50; rt_val = 32'd3; div_busy = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step();
      #1;
      if (t_stall) stalls++;
      if (t_hi_w || t_lo_w) writes++;
      if (t_err) early_err++;
      if (c == 10) last_stall = t_stall;
    end
    op_valid = 1'b0;
    $display("timeout: stalls=%0d writes=%0d last_stall=%b", stalls, writes, last_stall);
    total++;
    if (stalls !== 10 || last_stall !== 1'b0) begin
      bad++; $display("FAIL timeout_stall: got stalls=%0d last=%b want 10/0", stalls, last_stall);
    end
    total++;
    if (writes !== 0 || early_err !== 0) begin
      bad++; $display("FAIL timeout_no_write: got writes=%0d early_err=%0d want 0/0", writes, early_err);
    end
    step(); #1;
    total++;
    if (t_err !== 1'b1 || t_stall !== 1'b0 || t_hi_w !== 1'b0 || t_lo_w !== 1'b0) begin
      bad++; $display("FAIL timeout_err: got err=%b stall=%b w=%b%b want 1 0 00", t_err, t_stall, t_hi_w, t_lo_w);
    end
    div_busy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #1;
    total++;
    if (t_err !== 1'b1) begin
      bad++; $display("FAIL timeout_err_sticky: got %b want 1", t_err);
    end
    $display("timeout err held: err=%b", t_err);
    rst = 1'b0;
    step(); #1;
    total++;
    if (t_err !== 1'b0) begin
      bad++; $display("FAIL timeout_err_cleared: got %b want 0", t_err);
    end
    rst = 1'b1;
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_mult();
    test_div_by_zero();
    test_div();
    test_div_fast();
    test_divu_latched();
    test_reset_mid_divide();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
